// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder sharing block.
package adder_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 17;
  localparam int DEF_NREQ  = 4;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_n.sv
// Plain combinational WIDTH-bit adder with carry in and carry out.
module adder_n #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_rr_pick.sv
// Rotating-priority picker: first set req bit at or above ptr, wrapping to 0.
module adder_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  localparam int IW = IDW + 1;

  // One spare bit so ptr + offset never wraps before the modulo fold.
  logic [IW-1:0] cand;

  // Scan offsets 0..NREQ-1 from ptr; the first requesting index wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + IW'(k);
      if (cand >= IW'(NREQ)) cand = cand - IW'(NREQ);
      if (!gnt_any && req[cand[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one adder_n among NREQ valid/ready requesters with round-robin
// arbitration and a single registered response channel.
// Optional feature: define ADDER_ARB_OVF_EN to add the rsp_ovf signed-overflow output.
module adder_share_arb
  import adder_arb_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  NREQ  = DEF_NREQ,
  localparam int IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   ptr_next;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  adder_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  adder_n #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Pointer moves to the slot just past the winner so it gets lowest priority next time.
  assign ptr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // Mux out the winning requester's operands.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  // Accept is offered only to the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  // Arbitration FSM with operand capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here, including the operand and response holding registers, has a reset value so an aborted op leaves nothing behind.
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
`ifdef ADDER_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_cin <= sel_cin;
            op_id  <= gnt_idx;
            rr_ptr <= ptr_next;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= op_id;
`ifdef ADDER_ARB_OVF_EN
          rsp_ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed cases plus randomized
// traffic compared against a behavioural round-robin/arithmetic model.
module tb_adder_share_arb;

  localparam int WIDTH = 17;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
`ifdef ADDER_ARB_OVF_EN
  logic                  rsp_ovf;
`endif

  adder_share_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: what each requester presents, who is asking, and where priority starts.
  logic [WIDTH-1:0] ma [NREQ];
  logic [WIDTH-1:0] mb [NREQ];
  logic             mc [NREQ];
  int               vmask;
  int               model_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    logic [NREQ*WIDTH-1:0] pa, pb;
    logic [NREQ-1:0]       pc;
    pa = '0;
    pb = '0;
    pc = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pa = (pa << WIDTH) | (NREQ*WIDTH)'(ma[i]);
      pb = (pb << WIDTH) | (NREQ*WIDTH)'(mb[i]);
      pc = (pc << 1) | NREQ'(mc[i]);
    end
    req_a     = pa;
    req_b     = pb;
    req_cin   = pc;
    req_valid = NREQ'(vmask);
  endtask

  // Round-robin rule: nearest asking requester at or after the pointer, wrapping.
  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (model_ptr + k) % NREQ;
      if (((vmask >> j) & 1) == 1) return j;
    end
    return -1;
  endfunction

  task automatic randomize_req(input int i);
    ma[i] = WIDTH'($urandom);
    mb[i] = WIDTH'($urandom);
    mc[i] = 1'($urandom);
  endtask

  // One complete transaction from offer to response handshake.
  task automatic run_op(input int stall, input bit early);
    int               g;
    logic [WIDTH:0]   esum;
    logic             eovf;
    logic [WIDTH-1:0] ea, eb;
    logic             ec;
    g = exp_grant();
    rsp_ready = early;
    apply_inputs();
    #1;
    check("grant_onehot", 64'(req_ready), 64'(NREQ'(1) << g));
    ea   = ma[g];
    eb   = mb[g];
    ec   = mc[g];
    esum = {1'b0, ea} + {1'b0, eb} + (WIDTH+1)'(ec);
    eovf = (ea[WIDTH-1] == eb[WIDTH-1]) && (esum[WIDTH-1] != ea[WIDTH-1]);
    @(posedge clk); #1;
    model_ptr = (g + 1) % NREQ;
    randomize_req(g);
    apply_inputs();
    check("exec_rsp_valid", 64'(rsp_valid), 64'(0));
    check("exec_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_id", 64'(rsp_id), 64'(g));
    check("rsp_sum", 64'(rsp_sum), 64'(esum[WIDTH-1:0]));
    check("rsp_cout", 64'(rsp_cout), 64'(esum[WIDTH]));
`ifdef ADDER_ARB_OVF_EN
    check("rsp_ovf", 64'(rsp_ovf), 64'(eovf));
`else
    if (eovf) begin end
`endif
    if (!early) begin
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("hold_valid", 64'(rsp_valid), 64'(1));
        check("hold_id", 64'(rsp_id), 64'(g));
        check("hold_sum", 64'(rsp_sum), 64'(esum[WIDTH-1:0]));
        check("hold_cout", 64'(rsp_cout), 64'(esum[WIDTH]));
        check("hold_req_ready", 64'(req_ready), 64'(0));
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("rsp_done", 64'(rsp_valid), 64'(0));
    rsp_ready = 1'b0;
  endtask

  // Abort an op with reset while in EXEC (or RESP) and confirm nothing is issued.
  task automatic reset_mid(input int who, input bit in_resp);
    vmask = 1 << who;
    rsp_ready = 1'b0;
    apply_inputs();
    @(posedge clk); #1;
    if (in_resp) begin
      @(posedge clk); #1;
      check("pre_rst_valid", 64'(rsp_valid), 64'(1));
    end
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_sum", 64'(rsp_sum), 64'(0));
    vmask = 0;
    apply_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    model_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      mc[i] = 1'b0;
    end
    model_ptr = 0;
    vmask     = NREQ'(4'hF);
    rsp_ready = 1'b0;
    rst       = 1'b1;
    apply_inputs();

    // Reset state, with every requester asking: nothing may be accepted.
    #3;
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));
    check("reset_rsp_sum", 64'(rsp_sum), 64'(0));
    check("reset_rsp_cout", 64'(rsp_cout), 64'(0));
    vmask = 0;
    apply_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_no_req_ready", 64'(req_ready), 64'(0));

    // Single requester 0: 3 + 4 + 1 = 8.
    vmask = 1;
    ma[0] = 17'd3;
    mb[0] = 17'd4;
    mc[0] = 1'b1;
    run_op(0, 1'b0);
    check("basic_sum_const", 64'(rsp_sum), 64'(8));

    // All requesters asking continuously: rotation through every id.
    vmask = 4'hF;
    for (int i = 0; i < NREQ; i++) randomize_req(i);
    for (int n = 0; n < 5; n++) run_op(0, 1'b1);

    // Full-width wrap: 1FFFF + 00001 -> sum 0, carry out, no signed overflow.
    vmask = 1 << model_ptr;
    ma[model_ptr] = 17'h1FFFF;
    mb[model_ptr] = 17'h00001;
    mc[model_ptr] = 1'b0;
    run_op(1, 1'b0);

    // Positive + positive crossing the sign bit: 0FFFF + 00001 -> 10000, overflow.
    vmask = 1 << model_ptr;
    ma[model_ptr] = 17'h0FFFF;
    mb[model_ptr] = 17'h00001;
    mc[model_ptr] = 1'b0;
    run_op(0, 1'b0);

    // Back-pressure: two requesters, consumer stalls for 5 cycles.
    vmask = 3;
    run_op(5, 1'b0);
    run_op(2, 1'b0);

    // Reset during EXEC, then during RESP; next grant must restart at requester 0.
    reset_mid(2, 1'b0);
    vmask = 4'hF;
    run_op(0, 1'b0);
    check("after_rst_ptr", 64'(model_ptr), 64'(1));
    reset_mid(3, 1'b1);
    vmask = 4'hE;
    run_op(0, 1'b0);

    // Randomized traffic: random masks, operands, stalls and early rsp_ready.
    for (int n = 0; n < 60; n++) begin
      vmask = int'($urandom_range(1, 15));
      if (($urandom & 3) == 0) randomize_req(int'($urandom_range(0, NREQ - 1)));
      if (($urandom & 3) == 0) run_op(0, 1'b1);
      else run_op(int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
